// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI-to-Wishbone bridge: FSM encodings and command-byte layout.
package spi_ctrl_pkg;

    localparam int SPI_ADDR_W = 7;
    localparam int CMD_WR_BIT = 7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WDATA   = 3'd1;
    localparam logic [2:0] ST_WR_BUS  = 3'd2;
    localparam logic [2:0] ST_RD_BUS  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

endpackage

// File: rtl/spi_ctrl_if.sv
// Wishbone master-side bundle driven by the SPI bridge.
interface spi_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_stb_o;
    logic              wb_ack_i;
    logic              wb_we_o;

    modport master (
        output wb_addr_o, wb_dat_o, wb_stb_o, wb_we_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_dat_o, wb_stb_o, wb_we_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/spi_ctrl_sr.sv
// SPI pin synchronizers, SCK fall detection, MSB-first shift register and byte framing.
module spi_sr
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              byte_rdy,
    output logic [DATA_W-1:0] rx_data
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_d;
    logic [DATA_W-1:0]      sr;
    logic [CNT_W-1:0]       cnt;
    logic                   sck_s, ss_s, mosi_s, fall;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign fall   = sck_d & ~sck_s;
    assign miso   = ~ss_s & sr[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            byte_rdy  <= 1'b0;
            rx_data   <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            byte_rdy  <= 1'b0;

            // Parallel load wins; a completed byte leaves zeros behind so MISO idles at 0x00.
            if (load)
                sr <= load_data;
            else if (ss_s && cnt != '0)
                sr <= '0;
            else if (fall && !ss_s)
                sr <= (cnt == CNT_LAST) ? '0 : {sr[DATA_W-2:0], mosi_s};

            if (ss_s) begin
                cnt <= '0;
            end else if (fall) begin
                if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    byte_rdy <= 1'b1;
                    rx_data  <= {sr[DATA_W-2:0], mosi_s};
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_ctrl.sv
// SPI slave to Wishbone master bridge: command byte (R/W + 7-bit address) then data byte.
module spi_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    spi_ctrl_if.master wb
);
    logic [2:0]        state;
    logic              byte_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              load;

    // Read data is captured into the shifter on the ack edge, ready for the host's dummy byte.
    assign load = (state == ST_RD_BUS) && wb.wb_ack_i;

    spi_sr #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sr (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_i),
        .sck       (spi_sck),
        .ss        (spi_ss),
        .mosi      (spi_mosi),
        .miso      (spi_miso),
        .load      (load),
        .load_data (wb.wb_dat_i),
        .byte_rdy  (byte_rdy),
        .rx_data   (rx_data)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state        <= ST_IDLE;
            wb.wb_addr_o <= '0;
            wb.wb_dat_o  <= '0;
            wb.wb_stb_o  <= 1'b0;
            wb.wb_we_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (byte_rdy) begin
                    wb.wb_addr_o <= ADDR_W'(rx_data[SPI_ADDR_W-1:0]);
                    if (rx_data[CMD_WR_BIT]) begin
                        state <= ST_WDATA;
                    end else begin
                        state       <= ST_RD_BUS;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_stb_o <= 1'b1;
                    end
                end
                ST_WDATA: if (byte_rdy) begin
                    wb.wb_dat_o <= rx_data;
                    wb.wb_we_o  <= 1'b1;
                    wb.wb_stb_o <= 1'b1;
                    state       <= ST_WR_BUS;
                end
                ST_WR_BUS: if (wb.wb_ack_i) begin
                    wb.wb_stb_o <= 1'b0;
                    wb.wb_we_o  <= 1'b0;
                    state       <= ST_IDLE;
                end
                ST_RD_BUS: if (wb.wb_ack_i) begin
                    wb.wb_stb_o <= 1'b0;
                    state       <= ST_RD_DATA;
                end
                ST_RD_DATA: if (byte_rdy) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench: SPI host driver plus a 256x8 Wishbone RAM slave with programmable ack delay.
module tb_spi_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic ss = 1'b1;
    logic mosi = 1'b0;
    logic miso;

    always #5 clk = ~clk;

    spi_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    spi_ctrl #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .spi_sck  (sck),
        .spi_ss   (ss),
        .spi_mosi (mosi),
        .spi_miso (miso),
        .wb       (bus)
    );

    // Wishbone RAM slave
    bit   [7:0] ram [256];
    int         ack_dly = 0;
    bit         ack_off = 1'b0;
    int         stb_cnt = 0;
    int         n_ack = 0;
    int         stab_err = 0;
    logic [7:0] last_addr = '0;
    logic       last_we = 1'b0;
    logic [7:0] last_dat = '0;
    logic       hold = 1'b0;
    logic       ack_prev = 1'b0;
    logic [16:0] hold_val = '0;

    assign bus.wb_ack_i = bus.wb_stb_o && !ack_off && (stb_cnt == ack_dly);
    assign bus.wb_dat_i = ram[bus.wb_addr_o];

    always @(posedge clk) begin
        if (bus.wb_stb_o && bus.wb_ack_i) begin
            n_ack     <= n_ack + 1;
            last_addr <= bus.wb_addr_o;
            last_we   <= bus.wb_we_o;
            last_dat  <= bus.wb_dat_o;
            if (bus.wb_we_o) ram[bus.wb_addr_o] <= bus.wb_dat_o;
        end
        if (bus.wb_stb_o && !bus.wb_ack_i) stb_cnt <= stb_cnt + 1;
        else stb_cnt <= 0;
        if (rst_n && hold &&
            (!bus.wb_stb_o || {bus.wb_addr_o, bus.wb_we_o, bus.wb_dat_o} != hold_val))
            stab_err <= stab_err + 1;
        if (rst_n && ack_prev && bus.wb_stb_o)
            stab_err <= stab_err + 1;
        hold     <= rst_n && bus.wb_stb_o && !bus.wb_ack_i;
        ack_prev <= rst_n && bus.wb_stb_o && bus.wb_ack_i;
        hold_val <= {bus.wb_addr_o, bus.wb_we_o, bus.wb_dat_o};
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        sck  = 1'b1;
        mosi = b;
        repeat (4) @(negedge clk);
        m   = miso;
        sck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input bit tog,
                         output logic [7:0] rx1, output logic [7:0] rx2, output logic gap);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        xfer(cmd, rx1);
        repeat (4) @(negedge clk);
        gap = 1'b0;
        if (tog) begin
            ss = 1'b1;
            repeat (8) @(negedge clk);
            gap = miso;
            ss  = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (12) @(negedge clk);
        end
        xfer(data, rx2);
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic partial(input int nbits);
        logic m;
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) spi_bit(i[0] == 1'b0, m);
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        bit         tog;
        int         pre;
        int         dly;
        logic [7:0] exp_rx2;
        logic [7:0] exp_addr;
        logic       exp_we;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic [7:0] rx1, rx2;
        logic       gap;
        int         base;
        ack_dly = v.dly;
        if (v.pre > 0) partial(v.pre);
        base = n_ack;
        frame(v.cmd, v.data, v.tog, rx1, rx2, gap);
        check("miso_cmd_byte", rx1, 8'h00);
        check("miso_data_byte", rx2, v.exp_rx2);
        check("ack_count", n_ack - base, 1);
        check("wb_addr", last_addr, v.exp_addr);
        check("wb_we", last_we, v.exp_we);
        if (v.exp_we) check("wb_dat_o", last_dat, v.data);
        if (v.tog) check("miso_ss_high", gap, 1'b0);
    endtask

    vec_t vecs [9];

    initial begin
        logic [7:0] r1, r2;
        logic       g;
        int         base;

        vecs[0] = '{8'h80, 8'hDE, 1'b1, 0, 0, 8'h00, 8'h00, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 0, 0, 8'hDE, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 8'h5A, 1'b0, 0, 0, 8'h00, 8'h7F, 1'b1};
        vecs[3] = '{8'h7F, 8'h00, 1'b0, 0, 0, 8'h5A, 8'h7F, 1'b0};
        vecs[4] = '{8'h81, 8'h33, 1'b0, 4, 0, 8'h00, 8'h01, 1'b1};
        vecs[5] = '{8'h01, 8'h00, 1'b1, 0, 0, 8'h33, 8'h01, 1'b0};
        vecs[6] = '{8'h82, 8'hA5, 1'b0, 0, 3, 8'h00, 8'h02, 1'b1};
        vecs[7] = '{8'h02, 8'h00, 1'b0, 0, 3, 8'hA5, 8'h02, 1'b0};
        vecs[8] = '{8'h00, 8'h00, 1'b1, 0, 0, 8'hDE, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_stb", bus.wb_stb_o, 1'b0);
        check("rst_we", bus.wb_we_o, 1'b0);
        check("rst_addr", bus.wb_addr_o, 8'h00);
        check("rst_dat_o", bus.wb_dat_o, 8'h00);
        check("rst_miso", miso, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);
        check("ram0", ram[0], 8'hDE);
        check("ram1", ram[1], 8'h33);
        check("ram7f", ram[8'h7F], 8'h5A);

        // Slave that never acks: stb stays up, later bytes are ignored.
        ack_off = 1'b1;
        base = n_ack;
        frame(8'h84, 8'h11, 1'b0, r1, r2, g);
        frame(8'h00, 8'h00, 1'b1, r1, r2, g);
        check("stuck_acks", n_ack - base, 0);
        check("stuck_stb", bus.wb_stb_o, 1'b1);
        check("stuck_we", bus.wb_we_o, 1'b1);
        check("stuck_addr", bus.wb_addr_o, 8'h04);
        check("stuck_dat", bus.wb_dat_o, 8'h11);

        // Asynchronous reset in the middle of a command byte.
        partial(0);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, g);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stb", bus.wb_stb_o, 1'b0);
        check("mid_rst_we", bus.wb_we_o, 1'b0);
        check("mid_rst_addr", bus.wb_addr_o, 8'h00);
        check("mid_rst_dat", bus.wb_dat_o, 8'h00);
        check("mid_rst_miso", miso, 1'b0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        ss      = 1'b1;
        ack_off = 1'b0;
        repeat (8) @(negedge clk);

        run_vec('{8'h85, 8'h66, 1'b0, 0, 1, 8'h00, 8'h05, 1'b1});
        run_vec('{8'h05, 8'h00, 1'b1, 0, 1, 8'h66, 8'h05, 1'b0});
        check("ram4_unwritten", ram[4], 8'h00);
        check("bus_stability", stab_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
